// File: rtl/dmem_pkg.sv
// Shared types, func3 encodings and access-legality helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request fields latched at acceptance (address kept separately, its width is a parameter).
  typedef struct packed {
    logic        we;
    logic [2:0]  func3;
    logic [31:0] wdata;
  } req_t;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] lane);
    case (func3)
      F3_H, F3_HU: is_misaligned = lane[0];
      F3_W:        is_misaligned = (lane != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Stores only know B/H/W; loads additionally accept the unsigned B/H forms.
  function automatic logic is_illegal(input logic we, input logic [2:0] func3);
    if (we) begin
      is_illegal = !(func3 == F3_B || func3 == F3_H || func3 == F3_W);
    end else begin
      is_illegal = !(func3 == F3_B || func3 == F3_H || func3 == F3_W ||
                     func3 == F3_BU || func3 == F3_HU);
    end
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata;
  logic          done;
  logic          err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, rdata, done, err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, rdata, done, err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction/extension, store merge and alignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val_c,
  output logic [31:0] store_word_c,
  output logic        misalign_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed byte/half and extend it.
  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];
    load_val_c = '0;
    case (func3)
      F3_B:    load_val_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val_c = {24'b0, byte_sel};
      F3_H:    load_val_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val_c = {16'b0, half_sel};
      F3_W:    load_val_c = word;
      default: load_val_c = '0;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the current word.
  always_comb begin
    store_word_c = word;
    case (func3)
      F3_B:    store_word_c[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_word_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_word_c                          = wdata;
      default: store_word_c                          = word;
    endcase
  end

  assign misalign_c = is_misaligned(func3, lane);

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering one load/store at a time with a fixed response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 32
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  req_t            req_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     mem [DEPTH];
  logic            done_q, err_q;
  logic [31:0]     rdata_q;

  logic            accept_c, access_c;
  logic [IW-1:0]   word_idx;
  logic [31:0]     word_rd;
  logic [31:0]     load_val_c, store_word_c;
  logic            misalign_c, range_c, illegal_c, bad_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0)   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded controls; req_ready is intentionally combinational off the state register.
  always_comb begin
    bus.req_ready = 1'b0;
    accept_c      = 1'b0;
    access_c      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        accept_c      = bus.req_valid;
      end
      BUSY:    access_c = (cnt_q == '0);
      default: ;
    endcase
  end

  assign word_idx  = addr_q[IW+1:2];
  assign word_rd   = mem[word_idx];
  assign range_c   = ({1'b0, addr_q} >= (AW+1)'(4 * DEPTH));
  assign illegal_c = is_illegal(req_q.we, req_q.func3);
  assign bad_c     = misalign_c | range_c | illegal_c;

  dmem_lane_align u_lane_align (
    .func3        (req_q.func3),
    .lane         (addr_q[1:0]),
    .word         (word_rd),
    .wdata        (req_q.wdata),
    .load_val_c   (load_val_c),
    .store_word_c (store_word_c),
    .misalign_c   (misalign_c)
  );

  // Request latch, latency counter and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        req_q.we    <= bus.req_we;
        req_q.func3 <= bus.req_func3;
        req_q.wdata <= bus.req_wdata;
        addr_q      <= bus.req_addr;
        cnt_q       <= CW'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      done_q <= access_c;
      err_q  <= access_c & bad_c;
      if (access_c) begin
        rdata_q <= (bad_c || req_q.we) ? 32'h0 : load_val_c;
      end
    end
  end

  // RAM contents survive reset; a reset before the access edge leaves the array untouched.
  always_ff @(posedge clk) begin
    if (access_c && req_q.we && !bad_c) begin
      mem[word_idx] <= store_word_c;
    end
  end

  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, latency and handshake checks.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned AW      = 32;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   n_acc;
  int   last_acc;
  bit   chk_fall;
  exp_t sb_q[$];
  int   acc_q[$];
  logic [7:0] mb [4*DEPTH];

  dmem_responder_if #(.AW(AW)) bus ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by byte count.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output exp_t e);
    int unsigned sz;
    bit bad;
    logic [31:0] v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = (a >= 32'(4 * DEPTH));
    if (we) bad = bad | (f3 > 3'd2);
    else    bad = bad | (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
    bad = bad | ((a & 32'(sz - 1)) != 0);
    e.err    = bad;
    e.rd     = 32'h0;
    e.chk_rd = bad || !we;
    if (!bad) begin
      if (we) begin
        for (int i = 0; i < int'(sz); i++) mb[12'(a + 32'(i))] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mb[12'(a + 32'(i))];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        e.rd = v;
      end
    end
  endfunction

  // Edge counter and acceptance log (inputs sampled before the DUT updates).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && bus.req_valid && bus.req_ready) begin
      n_acc++;
      last_acc = cyc;
      acc_q.push_back(cyc);
    end
  end

  // Response monitor: pop expected result, check data, error, latency and single-cycle pulse.
  always @(negedge clk) begin
    exp_t e;
    if (chk_fall) begin
      check("done_fall", 32'(bus.done), 32'h0);
      chk_fall = 1'b0;
    end
    if (bus.done === 1'b1) begin
      chk_fall = 1'b1;
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("err", 32'(bus.err), 32'(e.err));
        if (e.chk_rd) check("rdata", bus.rdata, e.rd);
        if (acc_q.size() != 0) check("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY));
      end
    end
  end

  task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit track);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    if (track) begin
      model(we, f3, a, wd, e);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    int a0 = n_acc;
    int n  = 0;
    while (n_acc == a0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n_acc == a0) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    drive(we, f3, a, wd, 1'b1);
    wait_accept();
    bus.req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int a_edge;
    n_vec = 0; n_err = 0; cyc = 0; n_acc = 0; last_acc = 0; chk_fall = 1'b0;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_func3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_done",  32'(bus.done), 32'h0);
    check("rst_err",   32'(bus.err), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Reset one edge into BUSY aborts the store.
    xact(1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    drive(1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    wait_accept();
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'h1);
    check("abort_done",  32'(bus.done), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    acc_q.delete();
    @(negedge clk);
    check("abort_release_ready", 32'(bus.req_ready), 32'h1);
    xact(1'b0, 3'b010, 32'h10, 32'h0);

    // Latency and handshake.
    drive(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b1);
    wait_accept();
    check("ready_busy", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 1'b0;
    wait_drain();
    xact(1'b0, 3'b010, 32'h20, 32'h0);

    // Sub-word accesses.
    xact(1'b1, 3'b000, 32'h21, 32'h0000005A);
    xact(1'b0, 3'b000, 32'h21, 32'h0);
    xact(1'b0, 3'b010, 32'h20, 32'h0);
    xact(1'b0, 3'b001, 32'h22, 32'h0);
    xact(1'b0, 3'b101, 32'h22, 32'h0);

    // Misaligned and illegal encodings.
    xact(1'b0, 3'b010, 32'h22, 32'h0);
    xact(1'b1, 3'b001, 32'h21, 32'h0000FFFF);
    xact(1'b0, 3'b010, 32'h20, 32'h0);
    xact(1'b0, 3'b011, 32'h20, 32'h0);
    xact(1'b1, 3'b100, 32'h20, 32'h12345678);
    xact(1'b0, 3'b010, 32'h20, 32'h0);

    // Negative byte/half extension.
    xact(1'b1, 3'b010, 32'h30, 32'h00000000);
    xact(1'b1, 3'b000, 32'h33, 32'h00000080);
    xact(1'b0, 3'b000, 32'h33, 32'h0);
    xact(1'b0, 3'b100, 32'h33, 32'h0);
    xact(1'b1, 3'b001, 32'h30, 32'h00008001);
    xact(1'b0, 3'b001, 32'h30, 32'h0);

    // Address range boundary.
    xact(1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5);
    xact(1'b0, 3'b010, 32'h1000, 32'h0);
    xact(1'b1, 3'b010, 32'hFFC, 32'h76543210);
    xact(1'b0, 3'b010, 32'hFFC, 32'h0);
    xact(1'b0, 3'b010, 32'h0, 32'h0);

    // Back-to-back: valid held, second request accepted the edge after done falls.
    drive(1'b1, 3'b010, 32'h40, 32'h0BADCAFE, 1'b1);
    wait_accept();
    a_edge = last_acc;
    drive(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
    wait_accept();
    check("b2b_interval", 32'(last_acc - a_edge), 32'(LATENCY + 2));
    bus.req_valid = 1'b0;
    wait_drain();

    // Randomised traffic over a preloaded window.
    for (int i = 0; i < 16; i++) xact(1'b1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
